// File: rtl/mul4x4_seq_core_if.sv
// Operand/result handshake bundle for mul4x4_seq_core: the master side drives
// the operands and the result acceptance; the slave side is the core.
interface mul4x4_seq_core_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;
  logic       busy;
  logic [1:0] step;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy, step
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy, step
  );
endinterface

// File: rtl/mul4x4_seq_core.sv
// Sequential 4x4 shift-add multiplier: one partial product per cycle into an
// 8-bit accumulator. Define MUL4X4_SIGNED_EN for two's-complement operands.
module mul4x4_seq_core #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input logic clk,
  input logic rst_n,
  mul4x4_seq_core_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0] state;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [7:0] acc;
  logic [1:0] k;

  logic [3:0] pp;
  logic [4:0] sum5;
  logic [2:0] k_top;
  logic [7:0] acc_step;
  logic       last_step;
  logic       do_fix;

`ifdef MUL4X4_SIGNED_EN
  logic sign_q;

  function automatic logic [3:0] mag(input logic [3:0] v);
    return v[3] ? (~v + 4'd1) : v;
  endfunction

  // A zero magnitude product stays +0, so negation only when both are nonzero.
  assign do_fix = sign_q && (ra != 4'd0) && (rb != 4'd0);
`else
  assign do_fix = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    pp        = rb[k] ? ra : 4'd0;
    sum5      = {1'b0, acc[k +: 4]} + {1'b0, pp};
    k_top     = {1'b0, k} + 3'd4;
    acc_step  = acc;
    acc_step[k +: 4] = sum5[3:0];
    // Bit k+4 is still zero before this step, so XOR with the carry is exact.
    acc_step[k_top]  = acc[k_top] ^ sum5[4];
    last_step = (k == 2'd3) ||
                (EARLY_EXIT && ((rb >> ({1'b0, k} + 3'd1)) == 4'd0));
  end

  // NOTE: state registers use non-blocking assignments and reset asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ra    <= 4'd0;
      rb    <= 4'd0;
      acc   <= 8'd0;
      k     <= 2'd0;
`ifdef MUL4X4_SIGNED_EN
      sign_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
`ifdef MUL4X4_SIGNED_EN
            ra     <= mag(bus.a);
            rb     <= mag(bus.b);
            sign_q <= bus.a[3] ^ bus.b[3];
`else
            ra     <= bus.a;
            rb     <= bus.b;
`endif
            acc    <= 8'd0;
            k      <= 2'd0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_step;
          if (last_step) begin
            k     <= 2'd0;
            state <= do_fix ? S_FIX : S_DONE;
          end else begin
            k <= k + 2'd1;
          end
        end
`ifdef MUL4X4_SIGNED_EN
        S_FIX: begin
          acc   <= ~acc + 8'd1;
          state <= S_DONE;
        end
`endif
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state == S_RUN) || (state == S_FIX);
  assign bus.step      = (state == S_RUN) ? k : 2'd0;
  assign bus.product   = acc;

endmodule

// File: tb/tb_mul4x4_seq_core.sv
// Bench for mul4x4_seq_core: two instances (EARLY_EXIT 0 and 1) share stimulus
// and are compared every cycle against an arithmetic latency/product model.
module tb_mul4x4_seq_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tb_in_valid = 1'b0;
  logic [3:0] tb_a = 4'd0;
  logic [3:0] tb_b = 4'd0;
  logic       tb_out_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mul4x4_seq_core_if if0 ();
  mul4x4_seq_core_if if1 ();

  assign if0.in_valid  = tb_in_valid;
  assign if0.a         = tb_a;
  assign if0.b         = tb_b;
  assign if0.out_ready = tb_out_ready;
  assign if1.in_valid  = tb_in_valid;
  assign if1.a         = tb_a;
  assign if1.b         = tb_b;
  assign if1.out_ready = tb_out_ready;

  mul4x4_seq_core #(.EARLY_EXIT(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mul4x4_seq_core #(.EARLY_EXIT(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic       d_in_ready [2];
  logic       d_out_valid[2];
  logic       d_busy     [2];
  logic [1:0] d_step     [2];
  logic [7:0] d_product  [2];

  assign d_in_ready[0] = if0.in_ready;   assign d_in_ready[1] = if1.in_ready;
  assign d_out_valid[0] = if0.out_valid; assign d_out_valid[1] = if1.out_valid;
  assign d_busy[0] = if0.busy;           assign d_busy[1] = if1.busy;
  assign d_step[0] = if0.step;           assign d_step[1] = if1.step;
  assign d_product[0] = if0.product;     assign d_product[1] = if1.product;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: product by plain arithmetic, latency from steps needed plus negation.
  function automatic void model_op(input logic [3:0] av, input logic [3:0] bv, input bit ee,
                                   output logic [7:0] p, output int runs, output int lat);
    int sa, sb, prod, mb, fix;
`ifdef MUL4X4_SIGNED_EN
    sa   = av[3] ? int'(av) - 16 : int'(av);
    sb   = bv[3] ? int'(bv) - 16 : int'(bv);
    prod = sa * sb;
    mb   = (sb < 0) ? -sb : sb;
    fix  = (prod < 0) ? 1 : 0;
`else
    sa   = int'(av);
    sb   = int'(bv);
    prod = sa * sb;
    mb   = sb;
    fix  = 0;
`endif
    p = prod[7:0];
    if (ee) begin
      runs = 1;
      for (int i = 0; i < 4; i++) if (mb[i]) runs = i + 1;
    end else begin
      runs = 4;
    end
    lat = runs + fix;
  endfunction

  typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
  mphase_t    m_phase[2] = '{M_IDLE, M_IDLE};
  int         m_cnt  [2] = '{0, 0};
  int         m_runs [2] = '{0, 0};
  int         m_lat  [2] = '{0, 0};
  logic [7:0] m_prod [2] = '{8'd0, 8'd0};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_phase[i] = M_IDLE;
        m_cnt[i]   = 0;
      end else begin
        case (m_phase[i])
          M_IDLE: if (tb_in_valid) begin
            model_op(tb_a, tb_b, (i == 1), m_prod[i], m_runs[i], m_lat[i]);
            m_cnt[i]   = 0;
            m_phase[i] = M_BUSY;
          end
          M_BUSY: begin
            m_cnt[i]++;
            if (m_cnt[i] == m_lat[i]) m_phase[i] = M_DONE;
          end
          M_DONE: if (tb_out_ready) m_phase[i] = M_IDLE;
          default: m_phase[i] = M_IDLE;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [1:0] exp_step;
      exp_step = (m_phase[i] == M_BUSY && m_cnt[i] < m_runs[i]) ? 2'(m_cnt[i]) : 2'd0;
      check($sformatf("in_ready[%0d]", i),  32'(d_in_ready[i]),  32'(m_phase[i] == M_IDLE));
      check($sformatf("out_valid[%0d]", i), 32'(d_out_valid[i]), 32'(m_phase[i] == M_DONE));
      check($sformatf("busy[%0d]", i),      32'(d_busy[i]),      32'(m_phase[i] == M_BUSY));
      check($sformatf("step[%0d]", i),      32'(d_step[i]),      32'(exp_step));
      if (m_phase[i] == M_DONE)
        check($sformatf("product[%0d]", i), 32'(d_product[i]), 32'(m_prod[i]));
      if (!rst_n)
        check($sformatf("rst_product[%0d]", i), 32'(d_product[i]), 32'h0);
    end
  end

  task automatic wait_idle();
    int c;
    for (c = 0; c < 40; c++) begin
      if (if0.in_ready && if1.in_ready) break;
      @(posedge clk); #1;
    end
    if (c == 40) check("idle_timeout", 32'(if0.in_ready && if1.in_ready), 32'h1);
  endtask

  task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input int hold,
                        output logic [7:0] p0, output logic [7:0] p1,
                        output int l0, output int l1);
    wait_idle();
    tb_in_valid  = 1'b1;
    tb_a         = av;
    tb_b         = bv;
    tb_out_ready = (hold == 0);
    @(posedge clk); #1;
    l0 = -1; l1 = -1; p0 = 8'd0; p1 = 8'd0;
    for (int c = 1; c <= 30 && (l0 < 0 || l1 < 0); c++) begin
      // Garbage operands while both cores are occupied must be ignored.
      if (!if0.in_ready && !if1.in_ready) begin
        tb_in_valid = 1'($urandom_range(0, 1));
        tb_a        = 4'($urandom);
        tb_b        = 4'($urandom);
      end else begin
        tb_in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (l0 < 0 && if0.out_valid) begin l0 = c; p0 = if0.product; end
      if (l1 < 0 && if1.out_valid) begin l1 = c; p1 = if1.product; end
    end
    tb_in_valid = 1'b0;
    if (l0 < 0) check("done_timeout0", 32'h0, 32'h1);
    if (l1 < 0) check("done_timeout1", 32'h0, 32'h1);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 tb_out_ready = 1'b1;
    end
    wait_idle();
  endtask

  logic [7:0] p0, p1;
  int l0, l1;

  initial begin
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_in_ready",  32'(if0.in_ready),  32'h1);
    check("reset_out_valid", 32'(if0.out_valid), 32'h0);
    check("reset_busy",      32'(if0.busy),      32'h0);
    check("reset_step",      32'(if0.step),      32'h0);
    check("reset_product",   32'(if0.product),   32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef MUL4X4_SIGNED_EN
    run_op(4'h8, 4'h7, 0, p0, p1, l0, l1);
    check("s_m8x7_p0", 32'(p0), 32'hC8);  check("s_m8x7_lat0", 32'(l0), 32'd5);
    check("s_m8x7_p1", 32'(p1), 32'hC8);  check("s_m8x7_lat1", 32'(l1), 32'd4);
    run_op(4'h8, 4'h8, 0, p0, p1, l0, l1);
    check("s_m8xm8_p0", 32'(p0), 32'h40); check("s_m8xm8_lat0", 32'(l0), 32'd4);
    run_op(4'hD, 4'h0, 0, p0, p1, l0, l1);
    check("s_m3x0_p0", 32'(p0), 32'h00);  check("s_m3x0_lat0", 32'(l0), 32'd4);
    check("s_m3x0_p1", 32'(p1), 32'h00);  check("s_m3x0_lat1", 32'(l1), 32'd1);
    run_op(4'h9, 4'h6, 3, p0, p1, l0, l1);
    check("s_m7x6_p0", 32'(p0), 32'hD6);
`else
    run_op(4'd15, 4'd15, 0, p0, p1, l0, l1);
    check("u_15x15_p0", 32'(p0), 32'hE1); check("u_15x15_lat0", 32'(l0), 32'd4);
    check("u_15x15_p1", 32'(p1), 32'hE1); check("u_15x15_lat1", 32'(l1), 32'd4);
    run_op(4'd9, 4'd6, 3, p0, p1, l0, l1);
    check("u_9x6_p0", 32'(p0), 32'h36);   check("u_9x6_lat1", 32'(l1), 32'd3);
    run_op(4'd13, 4'd1, 0, p0, p1, l0, l1);
    check("u_13x1_p1", 32'(p1), 32'h0D);  check("u_13x1_lat1", 32'(l1), 32'd1);
    check("u_13x1_lat0", 32'(l0), 32'd4);
    run_op(4'd13, 4'd0, 0, p0, p1, l0, l1);
    check("u_13x0_p1", 32'(p1), 32'h00);  check("u_13x0_lat1", 32'(l1), 32'd1);
`endif

    // Abort mid-operation at step 2, then a fresh accept must be clean.
    wait_idle();
    tb_in_valid = 1'b1; tb_a = 4'd15; tb_b = 4'd15; tb_out_ready = 1'b1;
    @(posedge clk); #1 tb_in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("midrun_step", 32'(if0.step), 32'd2);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready",  32'(if0.in_ready),  32'h1);
    check("abort_out_valid", 32'(if0.out_valid), 32'h0);
    check("abort_busy",      32'(if0.busy),      32'h0);
    check("abort_step",      32'(if0.step),      32'h0);
    check("abort_product",   32'(if0.product),   32'h0);
    check("abort_product1",  32'(if1.product),   32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_op(4'd2, 4'd3, 0, p0, p1, l0, l1);
    check("after_abort_p0", 32'(p0), 32'h06);
    check("after_abort_p1", 32'(p1), 32'h06);

    for (int n = 0; n < 60; n++)
      run_op(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)), p0, p1, l0, l1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
